// File: rtl/mdio_sta_gen2.sv
// mdio_sta_gen2: MDIO station-management master driving Clause 22/45 frames on mdc/mdio
module mdio_sta_gen2 #(
  parameter int CLK_DIV = 4,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stb,
  input  logic [1:0]  ST,
  input  logic [1:0]  OP,
  input  logic [4:0]  PHYADDR,
  input  logic [4:0]  REGADDR,
  input  logic [15:0] WR_DATA,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [15:0] RD_DATA,
  output logic        rd_valid,
  output logic        busy,
  output logic        done
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV / 2 - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(CLK_DIV / 2);
  localparam logic [5:0] PRE_LAST = 6'(PRE_LEN - 1);
  typedef enum logic [2:0] {IDLE, PREAMBLE, SEND, RECV, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ph;
  logic [5:0] bit_cnt;
  logic [31:0] frame;
  logic [15:0] shift;
  logic rd_type, active, bit_end;
  assign active = state == PREAMBLE || state == SEND || state == RECV;
  assign bit_end = ph == PH_LAST;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // next state: advance only on the last clk cycle of a bit period
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start_stb) state_nx = PRE_LEN > 0 ? PREAMBLE : SEND;
      PREAMBLE: if (bit_end && bit_cnt == PRE_LAST) state_nx = SEND;
      SEND:     if (bit_end && rd_type && bit_cnt == 6'd15) state_nx = RECV;
                else if (bit_end && bit_cnt == 6'd31) state_nx = DONE;
      RECV:     if (bit_end && bit_cnt == 6'd31) state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
  end
  // phase/bit counters, latched frame fields and read shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      ph      <= '0;
      bit_cnt <= '0;
      frame   <= '0;
      rd_type <= 1'b0;
      shift   <= '0;
      RD_DATA <= '0;
    end else begin
      if (state == IDLE && start_stb) begin
        frame   <= {ST, OP, PHYADDR, REGADDR, 2'b10, WR_DATA};
        rd_type <= OP[1];
      end
      ph <= (active && !bit_end) ? ph + 1'b1 : '0;
      bit_cnt <= !active ? '0 : !bit_end ? bit_cnt :
                 (state == PREAMBLE && state_nx == SEND) ? '0 : bit_cnt + 6'd1;
      if (state == RECV && ph == PH_RISE) shift <= {shift[14:0], mdio_in};
      if (state == RECV && state_nx == DONE) RD_DATA <= shift;
    end
  end
  // pad and status outputs; the frame bit index 31-bit_cnt is the bitwise inverse of bit_cnt[4:0]
  always_comb begin
    mdc      = active && ph >= PH_HIGH;
    mdio_oe  = state == PREAMBLE || (state == SEND && !(rd_type && bit_cnt >= 6'd14));
    mdio_out = state == PREAMBLE || (mdio_oe && state == SEND && frame[~bit_cnt[4:0]]);
    busy     = active;
    done     = state == DONE;
    rd_valid = state == DONE && rd_type;
  end
endmodule

// File: tb/tb_mdio_sta_gen2.sv
// tb_mdio_sta_gen2: table-driven and randomized frame checks against a cycle-level frame model
module tb_mdio_sta_gen2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [1:0] st = '0, op = '0;
  logic [4:0] phy = '0, rg = '0;
  logic [15:0] wr = '0;
  logic mdio_in = 1'b0;
  logic mdc0, out0, oe0, rv0, busy0, done0;
  logic mdc1, out1, oe1, rv1, busy1, done1;
  logic [15:0] rd0, rd1;
  int checks = 0;
  int failures = 0;
  logic [15:0] prev_rd [2] = '{16'h0, 16'h0};

  typedef struct {
    int d;
    logic [1:0] st, op;
    logic [4:0] phy, rg;
    logic [15:0] wr, rx, exp_rd;
    bit glitch;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mdio_sta_gen2 u0 (
    .clk(clk), .rst(rst), .start_stb(start0), .ST(st), .OP(op), .PHYADDR(phy),
    .REGADDR(rg), .WR_DATA(wr), .mdio_in(mdio_in), .mdc(mdc0), .mdio_out(out0),
    .mdio_oe(oe0), .RD_DATA(rd0), .rd_valid(rv0), .busy(busy0), .done(done0)
  );

  mdio_sta_gen2 #(.CLK_DIV(2), .PRE_LEN(0)) u1 (
    .clk(clk), .rst(rst), .start_stb(start1), .ST(st), .OP(op), .PHYADDR(phy),
    .REGADDR(rg), .WR_DATA(wr), .mdio_in(mdio_in), .mdc(mdc1), .mdio_out(out1),
    .mdio_oe(oe1), .RD_DATA(rd1), .rd_valid(rv1), .busy(busy1), .done(done1)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] obs(int d);
    return d == 0 ? {mdc0, oe0, out0, busy0, done0, rv0, rd0}
                  : {mdc1, oe1, out1, busy1, done1, rv1, rd1};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_start(int d, logic v);
    if (d == 0) start0 = v;
    else start1 = v;
  endtask

  task automatic run_frame(int idx, vec_t v);
    int div, pre, n;
    logic [31:0] fr;
    logic [15:0] old;
    bit rd;
    div = v.d == 0 ? 4 : 2;
    pre = v.d == 0 ? 32 : 0;
    n = (pre + 32) * div;
    fr = {v.st, v.op, v.phy, v.rg, 2'b10, v.wr};
    rd = v.op[1];
    old = prev_rd[v.d];
    st = v.st; op = v.op; phy = v.phy; rg = v.rg; wr = v.wr;
    set_start(v.d, 1'b1);
    @(negedge clk);
    chk($sformatf("f%0d idle", idx), obs(v.d), {6'b0, old});
    step;
    set_start(v.d, 1'b0);
    for (int k = 0; k < n; k++) begin
      int b, p, fb;
      logic e_oe, e_out;
      b = k / div;
      p = k % div;
      fb = b - pre;
      if (b < pre) begin
        e_oe = 1'b1;
        e_out = 1'b1;
      end else begin
        e_oe = !(rd && fb >= 14);
        e_out = e_oe & fr[31-fb];
      end
      mdio_in = (rd && b >= pre && fb >= 16) ? v.rx[31-fb] : 1'($urandom);
      if (v.glitch && k == 9) begin
        set_start(v.d, 1'b1);
        st = ~v.st; op = ~v.op; phy = ~v.phy; rg = ~v.rg; wr = ~v.wr;
      end
      if (v.glitch && k == 10) set_start(v.d, 1'b0);
      @(negedge clk);
      chk($sformatf("f%0d k=%0d", idx, k), obs(v.d),
          {1'(p >= div / 2), e_oe, e_out, 3'b100, old});
      step;
    end
    set_start(v.d, 1'b1);
    st = 2'($urandom); op = 2'($urandom); wr = 16'($urandom);
    @(negedge clk);
    chk($sformatf("f%0d done", idx), obs(v.d), {3'b000, 1'b0, 1'b1, rd, v.exp_rd});
    step;
    set_start(v.d, 1'b0);
    prev_rd[v.d] = v.exp_rd;
  endtask

  initial begin
    logic [15:0] m [2];
    vec_t r;
    int dc;
    tbl.push_back('{0, 2'b01, 2'b01, 5'h03, 5'h1F, 16'hA5C3, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{0, 2'b01, 2'b10, 5'h01, 5'h02, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0});
    tbl.push_back('{0, 2'b01, 2'b01, 5'h0A, 5'h05, 16'h1111, 16'h0000, 16'hBEEF, 1'b1});
    tbl.push_back('{0, 2'b00, 2'b11, 5'h07, 5'h03, 16'h0000, 16'h1357, 16'h1357, 1'b0});
    tbl.push_back('{1, 2'b00, 2'b11, 5'h02, 5'h01, 16'h0000, 16'h55AA, 16'h55AA, 1'b0});
    tbl.push_back('{1, 2'b00, 2'b00, 5'h04, 5'h01, 16'h1234, 16'h0000, 16'h55AA, 1'b0});
    tbl.push_back('{1, 2'b01, 2'b10, 5'h1F, 5'h1F, 16'h0000, 16'hC0DE, 16'hC0DE, 1'b1});
    m = '{16'h0, 16'h0};
    foreach (tbl[i]) if (tbl[i].op[1]) m[tbl[i].d] = tbl[i].rx;
    for (int i = 0; i < 8; i++) begin
      r.d = int'($urandom_range(0, 1));
      r.st = 2'($urandom); r.op = 2'($urandom);
      r.phy = 5'($urandom); r.rg = 5'($urandom);
      r.wr = 16'($urandom); r.rx = 16'($urandom);
      r.glitch = 1'($urandom);
      if (r.op[1]) m[r.d] = r.rx;
      r.exp_rd = m[r.d];
      tbl.push_back(r);
    end
    start0 = 1'b1;
    start1 = 1'b1;
    repeat (3) step;
    rst = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    chk("reset u0", obs(0), 22'h0);
    chk("reset u1", obs(1), 22'h0);
    step;
    foreach (tbl[i]) run_frame(i, tbl[i]);
    @(negedge clk);
    chk("final idle u0", obs(0), {6'b0, prev_rd[0]});
    chk("final idle u1", obs(1), {6'b0, prev_rd[1]});
    st = 2'b01; op = 2'b10; phy = 5'h01; rg = 5'h01; wr = 16'h0;
    start0 = 1'b1;
    step;
    start0 = 1'b0;
    repeat (210) begin
      mdio_in = 1'($urandom);
      step;
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    @(negedge clk);
    chk("reset mid-read", obs(0), 22'h0);
    dc = 0;
    repeat (300) begin
      @(negedge clk);
      if (done0 || busy0) dc++;
    end
    chk("no activity after reset", 64'(dc), 64'd0);
    step;
    prev_rd[0] = 16'h0;
    r = '{0, 2'b01, 2'b01, 5'h11, 5'h0C, 16'h5A5A, 16'h0000, 16'h0000, 1'b0};
    run_frame(99, r);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
